// File: rtl/sad_min_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : sad_min_tracker_if
// Brief    : Sample stream and result bus between Control and the SAD tracker.
// Revision : 1.0 - initial release
// ============================================================================
interface sad_min_tracker_if #(
    parameter int SAD_W = 16,
    parameter int IDX_W = 6
);
    logic             start;
    logic             in_valid;
    logic [7:0]       c;
    logic [7:0]       p;
    logic [7:0]       p_prime;
    logic             in_ready;
    logic             done;
    logic [SAD_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;

    modport master (
        output start, in_valid, c, p, p_prime,
        input  in_ready, done, best_sad, best_idx
    );

    modport slave (
        input  start, in_valid, c, p, p_prime,
        output in_ready, done, best_sad, best_idx
    );
endinterface
`default_nettype wire

// File: rtl/sad_min_tracker.sv
`default_nettype none
// ============================================================================
// Module   : sad_min_tracker
// Brief    : Dual 16x16 SAD accumulation with minimum-SAD / index tracking.
// Revision : 1.0 - initial release
// ============================================================================
module sad_min_tracker #(
    parameter int PIX_PER_BLK = 256,
    parameter int NUM_BLK     = 16,
    parameter int SAD_W       = 16,
    parameter int IDX_W       = 6
) (
    input  wire logic        clk,
    input  wire logic        reset,
    sad_min_tracker_if.slave bus
);
    localparam int c_PIX_W = $clog2(PIX_PER_BLK);
    localparam int c_BLK_W = $clog2(NUM_BLK);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SAD_W-1:0]   r_sad_a;
    logic [SAD_W-1:0]   r_sad_b;
    logic [SAD_W-1:0]   r_min;
    logic [IDX_W-1:0]   r_idx;
    logic [c_PIX_W-1:0] r_pix;
    logic [c_BLK_W-1:0] r_blk;
    logic [SAD_W-1:0]   r_best_sad;
    logic [IDX_W-1:0]   r_best_idx;

    logic               w_accept;
    logic               w_last_pix;
    logic               w_last_blk;
    logic [SAD_W-1:0]   w_min_a;
    logic [IDX_W-1:0]   w_idx_a;
    logic [SAD_W-1:0]   w_min_b;
    logic [IDX_W-1:0]   w_idx_b;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // start has priority, so a sample presented alongside it is dropped
    assign w_accept   = bus.in_valid && (r_state == S_ACCUM) && !bus.start;
    assign w_last_pix = (r_pix == c_PIX_W'(PIX_PER_BLK - 1));
    assign w_last_blk = (r_blk == c_BLK_W'(NUM_BLK - 1));

    // Candidate 2k is checked first so that strict compares favour the lower index
    assign w_min_a = (r_sad_a < r_min)   ? r_sad_a : r_min;
    assign w_idx_a = (r_sad_a < r_min)   ? IDX_W'({r_blk, 1'b0}) : r_idx;
    assign w_min_b = (r_sad_b < w_min_a) ? r_sad_b : w_min_a;
    assign w_idx_b = (r_sad_b < w_min_a) ? IDX_W'({r_blk, 1'b1}) : w_idx_a;

    assign bus.in_ready = (r_state == S_ACCUM);
    assign bus.done     = (r_state == S_DONE);
    assign bus.best_sad = r_best_sad;
    assign bus.best_idx = r_best_idx;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_state_next = S_ACCUM;
            S_ACCUM:   if (w_accept && w_last_pix) w_state_next = S_COMPARE;
            S_COMPARE: w_state_next = w_last_blk ? S_DONE : S_ACCUM;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
        if (bus.start) w_state_next = S_ACCUM;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sad_a    <= '0;
            r_sad_b    <= '0;
            r_min      <= '1;
            r_idx      <= '0;
            r_pix      <= '0;
            r_blk      <= '0;
            r_best_sad <= '1;
            r_best_idx <= '0;
        end else if (bus.start) begin
            // Abort/restart leaves the previously reported result untouched
            r_sad_a <= '0;
            r_sad_b <= '0;
            r_min   <= '1;
            r_idx   <= '0;
            r_pix   <= '0;
            r_blk   <= '0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_accept) begin
                        r_sad_a <= r_sad_a + SAD_W'(abs_diff(bus.c, bus.p));
                        r_sad_b <= r_sad_b + SAD_W'(abs_diff(bus.c, bus.p_prime));
                        if (!w_last_pix) r_pix <= r_pix + 1'b1;
                    end
                end
                S_COMPARE: begin
                    r_min   <= w_min_b;
                    r_idx   <= w_idx_b;
                    r_sad_a <= '0;
                    r_sad_b <= '0;
                    r_pix   <= '0;
                    if (w_last_blk) begin
                        r_best_sad <= w_min_b;
                        r_best_idx <= w_idx_b;
                    end else begin
                        r_blk <= r_blk + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sad_min_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_min_tracker
// Brief    : Directed, table-driven self-checking bench for sad_min_tracker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sad_min_tracker;
    localparam int c_SAMPLES = 4096;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    sad_min_tracker_if #(.SAD_W(16), .IDX_W(6)) bus ();

    sad_min_tracker #(
        .PIX_PER_BLK(256),
        .NUM_BLK    (16),
        .SAD_W      (16),
        .IDX_W      (6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int mode;
        bit gaps;
        int exp_sad;
        int exp_idx;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Pixel patterns; mode 5 places the winner at candidate 24 with a later tie
    function automatic void gen(input int mode, input int blk,
                                output logic [7:0] c, output logic [7:0] p,
                                output logic [7:0] pp);
        c = 8'd100; p = 8'd90; pp = 8'd95;
        case (mode)
            0: begin c = 8'd10;  p = 8'd10; pp = 8'd10; end
            4: begin c = 8'd255; p = 8'd0;  pp = 8'd0;  end
            default: begin
                if ((mode == 2 || mode == 3) && blk == 5) pp = 8'd100;
                if (mode == 3 && blk == 9) p = 8'd100;
                if (mode == 5 && blk == 12) begin p = 8'd99; pp = 8'd98; end
                if (mode == 5 && blk == 13) pp = 8'd99;
            end
        endcase
    endfunction

    task automatic pulse_start(input bit with_valid);
        bus.start    = 1'b1;
        bus.in_valid = with_valid;
        bus.c        = 8'd255;
        bus.p        = 8'd0;
        bus.p_prime  = 8'd0;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic feed(input int mode, input bit gaps, input int n, output int low);
        logic [7:0] c, p, pp;
        int guard;
        bit ok;
        low = 0;
        for (int i = 0; i < n; i++) begin
            gen(mode, i / 256, c, p, pp);
            bus.c = c; bus.p = p; bus.p_prime = pp; bus.in_valid = 1'b1;
            guard = 0;
            do begin
                ok = bus.in_ready;
                if (!ok) low++;
                @(posedge clk); #1;
                guard++;
            end while (!ok && guard < 8);
            if (!ok) begin
                chk("accept_timeout", 0, 1);
                return;
            end
            if (gaps && i != n - 1) begin
                bus.in_valid = 1'b0;
                bus.c = 8'd255; bus.p = 8'd0; bus.p_prime = 8'd0;
                if (!bus.in_ready) low++;
                @(posedge clk); #1;
            end
        end
        // Garbage held valid through COMPARE/DONE must be ignored
        bus.in_valid = 1'b1;
        bus.c = 8'd255; bus.p = 8'd0; bus.p_prime = 8'd0;
    endtask

    task automatic check_tail(input int exp_sad, input int exp_idx);
        chk("compare_done_low", bus.done, 0);
        chk("compare_ready_low", bus.in_ready, 0);
        @(posedge clk); #1;
        chk("done_pulse", bus.done, 1);
        chk("done_ready_low", bus.in_ready, 0);
        chk("best_sad", bus.best_sad, exp_sad);
        chk("best_idx", bus.best_idx, exp_idx);
        @(posedge clk); #1;
        chk("done_single", bus.done, 0);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int low;
        int seen_done;

        vecs[0] = '{0, 1'b0, 0,     0};
        vecs[1] = '{1, 1'b0, 1280,  1};
        vecs[2] = '{2, 1'b0, 0,     11};
        vecs[3] = '{3, 1'b0, 0,     11};
        vecs[4] = '{4, 1'b0, 65280, 0};
        vecs[5] = '{5, 1'b0, 256,   24};
        vecs[6] = '{1, 1'b1, 1280,  1};
        vecs[7] = '{5, 1'b1, 256,   24};

        reset = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0;
        bus.c = 8'd0; bus.p = 8'd0; bus.p_prime = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_best_sad", bus.best_sad, 16'hFFFF);
        chk("rst_best_idx", bus.best_idx, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            pulse_start(1'b0);
            feed(vecs[v].mode, vecs[v].gaps, c_SAMPLES, low);
            chk("ready_low_cycles", low, 15);
            check_tail(vecs[v].exp_sad, vecs[v].exp_idx);
            repeat (2) @(posedge clk);
            #1;
        end

        // Abort at block 3 sample 100; the start cycle also carries a valid sample
        pulse_start(1'b0);
        feed(1, 1'b0, 3 * 256 + 100, low);
        pulse_start(1'b1);
        chk("abort_keeps_sad", bus.best_sad, 256);
        chk("abort_keeps_idx", bus.best_idx, 24);
        chk("abort_in_accum", bus.in_ready, 1);
        feed(0, 1'b0, c_SAMPLES, low);
        chk("abort_ready_low_cycles", low, 15);
        check_tail(0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset in block 7: no done pulse follows
        pulse_start(1'b0);
        feed(1, 1'b0, 7 * 256 + 10, low);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_best_sad", bus.best_sad, 16'hFFFF);
        chk("midrst_best_idx", bus.best_idx, 0);
        seen_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen_done++;
        end
        chk("midrst_no_done", seen_done, 0);
        chk("midrst_idle", bus.in_ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
